// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the multi-cycle arithmetic unit controllers.
// The divider controller imports this package as well.
package mult_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiplier run length; the divider overrides MAX_COUNT at instantiation.
  localparam int MAX_COUNT_DEF = 30;

endpackage

// File: rtl/iter_counter.sv
// Programmable iteration sequencer: counts enabled steps after Start and reports
// Busy / Last / Done to the arithmetic unit's control FSM. Supports stall, abort, restart.
module iter_counter
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int MAX_COUNT = MAX_COUNT_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Limit,
  input  logic             Enable,
  input  logic             Abort,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Last,
  output logic             Done
);

  localparam logic [WIDTH-1:0] MAXC = MAX_COUNT[WIDTH-1:0];

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] lim_sat;
  logic             at_last;

  assign lim_sat = (Limit > MAXC) ? MAXC : Limit;
  assign at_last = (count == lim - WIDTH'(1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
      lim   <= '0;
    end else if (Abort) begin
      // Abort beats a simultaneous Start; Count is left as the run reached it.
      state <= IDLE;
    end else if (Start) begin
      lim   <= lim_sat;
      count <= '0;
      state <= (lim_sat == '0) ? DONE : RUN;
    end else begin
      case (state)
        RUN: if (Enable) begin
          count <= count + WIDTH'(1);
          if (at_last) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Count = count;
  assign Busy  = (state == RUN);
  assign Done  = (state == DONE);
  assign Last  = (state == RUN) && at_last;

endmodule

// File: tb/tb_iter_counter.sv
// Self-checking bench for iter_counter: vector table, directed corner sequences,
// and randomized traffic against a step-budget reference model.
module tb_iter_counter;

  localparam int W    = 6;
  localparam int MAXC = 30;

  logic         Clk = 1'b0;
  logic         Reset, Start, Enable, Abort;
  logic [W-1:0] Limit;
  logic [W-1:0] Count;
  logic         Busy, Last, Done;

  iter_counter #(.WIDTH(W), .MAX_COUNT(MAXC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Limit(Limit), .Enable(Enable),
    .Abort(Abort), .Count(Count), .Busy(Busy), .Last(Last), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int failed = 0;

  // Reference model: a run is "steps still owed"; Done is a flag for the cycle after the final step.
  int m_left = 0;
  int m_cnt  = 0;
  bit m_done = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit s, input int l, input bit e, input bit a);
    int  ls;
    bit  fin;
    if (r) begin
      m_left = 0; m_cnt = 0; m_done = 0;
    end else if (a) begin
      m_left = 0; m_done = 0;
    end else if (s) begin
      ls = (l > MAXC) ? MAXC : l;
      m_cnt = 0; m_left = ls; m_done = (ls == 0);
    end else begin
      fin = 0;
      if (m_left > 0 && e) begin
        m_cnt++; m_left--;
        fin = (m_left == 0);
      end
      m_done = fin;
    end
  endtask

  task automatic step(input bit r, input bit s, input int l, input bit e, input bit a);
    Reset = r; Start = s; Limit = W'(l); Enable = e; Abort = a;
    @(posedge Clk);
    #1;
    model(r, s, l, e, a);
    chk("mdl_count", int'(Count), m_cnt);
    chk("mdl_busy",  int'(Busy),  int'(m_left > 0));
    chk("mdl_last",  int'(Last),  int'(m_left == 1));
    chk("mdl_done",  int'(Done),  int'(m_done));
  endtask

  typedef struct {
    bit r, s; int l; bit e, a;
    int cnt; bit busy, last, done;
  } vec_t;

  vec_t vt[$];

  initial begin
    int busy_n, last_n, k, dones, first;
    bit seen;

    Reset = 1; Start = 0; Limit = '0; Enable = 0; Abort = 0;

    //        r  s  l   e  a   cnt busy last done
    vt.push_back('{1, 0, 0, 0, 0,  0, 0, 0, 0});  // reset state
    vt.push_back('{0, 1, 3, 1, 0,  0, 1, 0, 0});
    vt.push_back('{0, 0, 0, 1, 0,  1, 1, 0, 0});
    vt.push_back('{0, 0, 0, 0, 0,  1, 1, 0, 0});  // stall
    vt.push_back('{0, 0, 0, 1, 0,  2, 1, 1, 0});
    vt.push_back('{0, 0, 0, 1, 0,  3, 0, 0, 1});
    vt.push_back('{0, 0, 0, 0, 0,  3, 0, 0, 0});  // Count held in IDLE
    vt.push_back('{0, 1, 0, 1, 0,  0, 0, 0, 1});  // Limit=0
    vt.push_back('{0, 0, 0, 0, 0,  0, 0, 0, 0});
    vt.push_back('{0, 1, 63, 1, 0, 0, 1, 0, 0});  // saturates to 30
    vt.push_back('{0, 1, 2, 1, 1,  0, 0, 0, 0});  // abort+start in RUN
    vt.push_back('{0, 1, 2, 1, 1,  0, 0, 0, 0});  // abort+start in IDLE
    vt.push_back('{0, 1, 1, 1, 0,  0, 1, 1, 0});
    vt.push_back('{0, 1, 2, 1, 0,  0, 1, 0, 0});  // restart in RUN
    vt.push_back('{0, 0, 0, 1, 0,  1, 1, 1, 0});
    vt.push_back('{0, 0, 0, 1, 0,  2, 0, 0, 1});
    vt.push_back('{0, 1, 1, 1, 0,  0, 1, 1, 0});  // start during DONE
    vt.push_back('{0, 0, 0, 1, 0,  1, 0, 0, 1});
    vt.push_back('{1, 0, 0, 1, 0,  0, 0, 0, 0});

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].s, vt[i].l, vt[i].e, vt[i].a);
      chk($sformatf("vec%0d_count", i), int'(Count), vt[i].cnt);
      chk($sformatf("vec%0d_busy", i),  int'(Busy),  int'(vt[i].busy));
      chk($sformatf("vec%0d_last", i),  int'(Last),  int'(vt[i].last));
      chk($sformatf("vec%0d_done", i),  int'(Done),  int'(vt[i].done));
    end

    // Default 30-step run
    step(0, 1, 30, 1, 0);
    busy_n = int'(Busy); last_n = int'(Last); seen = 0; k = 0; first = 0;
    for (int i = 1; i <= 100 && !seen; i++) begin
      step(0, 0, 0, 1, 0);
      busy_n += int'(Busy); last_n += int'(Last);
      if (Done) begin seen = 1; k = i; first = int'(Count); end
    end
    chk("def_done_seen", int'(seen), 1);
    chk("def_done_cycle", k, 30);
    chk("def_busy_cycles", busy_n, 30);
    chk("def_last_cycles", last_n, 1);
    chk("def_done_count", first, 30);
    step(0, 0, 0, 1, 0);
    chk("def_idle_count", int'(Count), 30);
    chk("def_idle_done", int'(Done), 0);

    // Stall three cycles at Count=2 of a 5-step run
    step(0, 1, 5, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("stall_hold", int'(Count), 2);
    end
    seen = 0; k = 0;
    for (int i = 6; i <= 40 && !seen; i++) begin
      step(0, 0, 0, 1, 0);
      if (Done) begin seen = 1; k = i; end
    end
    chk("stall_done_cycle", k, 8);
    chk("stall_done_count", int'(Count), 5);

    // Abort at Count=7 of a 10-step run
    step(0, 1, 10, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0);
    chk("abort_pre_count", int'(Count), 7);
    step(0, 0, 0, 1, 1);
    chk("abort_count", int'(Count), 7);
    chk("abort_busy", int'(Busy), 0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1, 0);
      dones += int'(Done);
    end
    chk("abort_no_done", dones, 0);

    // Restart with Limit=4 at Count=2
    step(0, 1, 10, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 4, 1, 0);
    chk("restart_count", int'(Count), 0);
    dones = 0; first = 0;
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 0, 1, 0);
      if (Done) begin dones++; if (first == 0) first = i; end
    end
    chk("restart_done_cycle", first, 4);
    chk("restart_one_done", dones, 1);

    // Reset mid-run at Count=12, then a clean run
    step(0, 1, 20, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0);
    chk("rst_pre_count", int'(Count), 12);
    step(1, 0, 0, 1, 0);
    chk("rst_outs", int'({Count, Busy, Last, Done}), 0);
    step(0, 1, 2, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("rst_rerun_last", int'(Last), 1);
    step(0, 0, 0, 1, 0);
    chk("rst_rerun_done", int'(Done), 1);
    chk("rst_rerun_count", int'(Count), 2);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, s, e, a;
      int l;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 8));
      step(r, s, l, e, a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
